// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues one-outstanding imem reads, loads IF/ID, squashes on redirect.
// Optional FETCH_KILL_CNT_EN adds Kill_Count, a saturating count of discarded fetch words.
module fetch_ctrl #(
    parameter int unsigned         PC_W     = 9,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid
`ifdef FETCH_KILL_CNT_EN
    ,
    output logic [15:0]     Kill_Count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            kill, kill_nxt;
    logic [PC_W-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic            capture_hold;
    logic            word_ok;
    logic [PC_W-1:0] word_pc;
    logic [31:0]     word_instr;
    logic            discard;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            unused_brpc;

    assign target      = {BrPC[PC_W-1:2], 2'b00};
    assign pc_inc      = pc + PC_W'(4);
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_nxt     = kill;
        capture_hold = 1'b0;
        word_ok      = 1'b0;
        word_pc      = pc;
        word_instr   = imem_rdata;
        discard      = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                state_nxt = WAIT;
                // The request in flight targets the stale PC; mark its response for discard.
                if (PcSel) begin
                    pc_nxt   = target;
                    kill_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || PcSel) begin
                        discard   = 1'b1;
                        kill_nxt  = 1'b0;
                        state_nxt = FETCH;
                        if (PcSel) pc_nxt = target;
                    end else if (!Stall) begin
                        word_ok   = 1'b1;
                        pc_nxt    = pc_inc;
                        state_nxt = FETCH;
                    end else begin
                        capture_hold = 1'b1;
                        state_nxt    = HOLD;
                    end
                end else if (PcSel) begin
                    pc_nxt   = target;
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (PcSel) begin
                    discard   = 1'b1;
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else if (!Stall) begin
                    word_ok    = 1'b1;
                    word_pc    = hold_pc;
                    word_instr = hold_instr;
                    pc_nxt     = pc_inc;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (capture_hold) begin
            hold_pc    <= pc;
            hold_instr <= imem_rdata;
        end
    end

    // Flush beats stall; a stalled register keeps its word, otherwise an empty cycle is a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IfId_PC    <= '0;
            IfId_Instr <= '0;
            IfId_Valid <= 1'b0;
        end else if (PcSel) begin
            IfId_Valid <= 1'b0;
        end else if (Stall) begin
            IfId_Valid <= IfId_Valid;
        end else if (word_ok) begin
            IfId_PC    <= word_pc;
            IfId_Instr <= word_instr;
            IfId_Valid <= 1'b1;
        end else begin
            IfId_Valid <= 1'b0;
        end
    end

`ifdef FETCH_KILL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Kill_Count <= '0;
        end else if (discard && (Kill_Count != 16'hFFFF)) begin
            Kill_Count <= Kill_Count + 16'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed phases with a variable-latency memory model and a request/load scoreboard.
module tb_fetch_ctrl;

    localparam int unsigned PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = '0;
    logic            Stall = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [PC_W-1:0] IfId_PC;
    logic [31:0]     IfId_Instr;
    logic            IfId_Valid;
`ifdef FETCH_KILL_CNT_EN
    logic [15:0]     Kill_Count;
`endif

    fetch_ctrl #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Stall(Stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IfId_PC(IfId_PC), .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid)
`ifdef FETCH_KILL_CNT_EN
        , .Kill_Count(Kill_Count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] word_of(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | {23'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: responds mem_lat cycles after the capturing edge.
    int              mem_lat = 1;
    logic            busy;
    int              cnt;
    logic [PC_W-1:0] maddr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            busy        <= 1'b0;
            cnt         <= 0;
            maddr       <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (busy) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= word_of(maddr);
                    busy        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req) begin
                maddr <= imem_addr;
                if (mem_lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= word_of(imem_addr);
                end else begin
                    busy <= 1'b1;
                    cnt  <= mem_lat - 1;
                end
            end
        end
    end

    // Scoreboard monitor
    logic [PC_W-1:0] exp_req[$];
    logic [PC_W-1:0] exp_load[$];
    logic            mon_on = 1'b0;
    logic            pv = 1'b0;
    logic [PC_W-1:0] ppc = '0;
    logic [31:0]     pins = '0;

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (imem_req) begin
                if (exp_req.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
                end else begin
                    check("req_addr", 32'(imem_addr), 32'(exp_req.pop_front()));
                end
            end
            if (IfId_Valid && (!pv || IfId_PC != ppc || IfId_Instr != pins)) begin
                if (exp_load.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_load: got pc %h expected none", IfId_PC);
                end else begin
                    logic [PC_W-1:0] e;
                    e = exp_load.pop_front();
                    check("load_pc", 32'(IfId_PC), 32'(e));
                    check("load_instr", IfId_Instr, word_of(e));
                end
            end
        end
        pv   = IfId_Valid;
        ppc  = IfId_PC;
        pins = IfId_Instr;
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        reset   = 1'b1;
        mem_lat = lat;
        PcSel   = 1'b0;
        Stall   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("idle_after_release", 32'(imem_req), 32'd0);
    endtask

    task automatic wait_req(input logic [PC_W-1:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_addr == a) && n < 60);
        if (!(imem_req && imem_addr == a)) begin
            total++; bad++;
            $display("FAIL wait_req_timeout: got no request to %h expected one within 60 cycles", a);
        end
    endtask

    task automatic end_phase(input string name);
        mon_on = 1'b0;
        check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
        check({name, "_load_left"}, 32'(exp_load.size()), 32'd0);
        exp_req.delete();
        exp_load.delete();
    endtask

    task automatic push_req(input logic [PC_W-1:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_load(input logic [PC_W-1:0] a);
        exp_load.push_back(a);
    endtask

    initial begin
        reset = 1'b1;
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h000);
        check("rst_valid", 32'(IfId_Valid), 32'd0);
        check("rst_ifid_pc", 32'(IfId_PC), 32'd0);
        check("rst_ifid_instr", IfId_Instr, 32'd0);

        // Straight-line fetch, L=1
        do_reset(1);
        push_req(9'h000); push_req(9'h004); push_req(9'h008); push_req(9'h00C);
        push_load(9'h000); push_load(9'h004); push_load(9'h008);
        mon_on = 1'b1;
        wait_req(9'h00C);
        end_phase("straight");

        // Redirect during WAIT, L=3
        do_reset(3);
        push_req(9'h000); push_req(9'h004); push_req(9'h008); push_req(9'h040); push_req(9'h044);
        push_load(9'h000); push_load(9'h004); push_load(9'h040);
        mon_on = 1'b1;
        wait_req(9'h008);
        @(negedge clk);
        PcSel = 1'b1; BrPC = 32'h0000_0040;
        @(negedge clk);
        PcSel = 1'b0;
        check("wait_redirect_valid", 32'(IfId_Valid), 32'd0);
        check("wait_redirect_noreq", 32'(imem_req), 32'd0);
        wait_req(9'h044);
        end_phase("redir_wait");
`ifdef FETCH_KILL_CNT_EN
        check("kill_cnt_wait", 32'(Kill_Count), 32'd1);
`endif

        // Redirect coincident with rvalid; upper and low target bits ignored
        do_reset(1);
        push_req(9'h000); push_req(9'h004); push_req(9'h080); push_req(9'h084);
        push_load(9'h000); push_load(9'h080);
        mon_on = 1'b1;
        wait_req(9'h004);
        @(negedge clk);
        PcSel = 1'b1; BrPC = 32'hABCD_0083;
        @(negedge clk);
        PcSel = 1'b0;
        check("rvalid_redirect_valid", 32'(IfId_Valid), 32'd0);
        wait_req(9'h084);
        end_phase("redir_rvalid");
`ifdef FETCH_KILL_CNT_EN
        check("kill_cnt_rvalid", 32'(Kill_Count), 32'd1);
`endif

        // Stall into HOLD
        do_reset(1);
        push_req(9'h000); push_req(9'h004); push_req(9'h008); push_req(9'h00C);
        push_req(9'h010); push_req(9'h014);
        push_load(9'h000); push_load(9'h004); push_load(9'h008); push_load(9'h00C); push_load(9'h010);
        mon_on = 1'b1;
        wait_req(9'h010);
        Stall = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_noreq", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(IfId_Valid), 32'd1);
        check("hold_ifid_pc", 32'(IfId_PC), 32'h00C);
        check("hold_ifid_instr", IfId_Instr, word_of(9'h00C));
        Stall = 1'b0;
        wait_req(9'h014);
        end_phase("stall");
`ifdef FETCH_KILL_CNT_EN
        check("kill_cnt_stall", 32'(Kill_Count), 32'd0);
`endif

        // Redirect in HOLD with wrap
        do_reset(1);
        push_req(9'h000); push_req(9'h004); push_req(9'h1FC); push_req(9'h000);
        push_load(9'h000); push_load(9'h1FC);
        mon_on = 1'b1;
        wait_req(9'h004);
        Stall = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_before_redirect_valid", 32'(IfId_Valid), 32'd1);
        PcSel = 1'b1; BrPC = 32'hFFFF_FFFF;
        @(negedge clk);
        PcSel = 1'b0; Stall = 1'b0;
        check("hold_redirect_flush", 32'(IfId_Valid), 32'd0);
        wait_req(9'h000);
        end_phase("redir_hold");
`ifdef FETCH_KILL_CNT_EN
        check("kill_cnt_hold", 32'(Kill_Count), 32'd1);
`endif

        // Async reset mid-WAIT
        do_reset(3);
        push_req(9'h000); push_req(9'h004); push_req(9'h008);
        push_load(9'h000); push_load(9'h004);
        mon_on = 1'b1;
        wait_req(9'h008);
        end_phase("pre_async");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_addr", 32'(imem_addr), 32'h000);
        check("async_valid", 32'(IfId_Valid), 32'd0);
        check("async_ifid_pc", 32'(IfId_PC), 32'd0);
        check("async_ifid_instr", IfId_Instr, 32'd0);
`ifdef FETCH_KILL_CNT_EN
        check("async_kill_cnt", 32'(Kill_Count), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("release_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("release_first_req", 32'(imem_req), 32'd1);
        check("release_first_addr", 32'(imem_addr), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side consumer of the branch unit's redirect (`PcSel`, `BrPC`). Owns the program counter, issues one-outstanding instruction-memory reads, and loads the IF/ID pipeline register. On a redirect it squashes the IF/ID register and any in-flight fetch, then restarts at the target. It also honours hazard-unit stalls through a one-entry hold buffer.

## Interface
- `PC_W`, default 9: PC width in bits.
- `RESET_PC`, default 0: PC value loaded on reset, `PC_W` bits, word aligned.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `PcSel`  in  1: redirect request from the branch unit, 1 = take `BrPC`.
- `BrPC`  in  32: redirect target; bits [PC_W-1:2] used, bits [1:0] forced to 0.
- `Stall`  in  1: hazard stall; IF/ID holds its contents.
- `imem_req`  out  1: fetch request; the memory captures `imem_addr` on the edge where this is 1.
- `imem_addr`  out  PC_W: fetch address.
- `imem_rvalid`  in  1: response strobe, at least 1 cycle after the request.
- `imem_rdata`  in  32: response instruction, valid with `imem_rvalid`.
- `IfId_PC`  out  PC_W: PC of the instruction in IF/ID.
- `IfId_Instr`  out  32: instruction in IF/ID.
- `IfId_Valid`  out  1: IF/ID holds a live instruction. 0 means bubble.
- `Kill_Count`  out  16: exists only with `FETCH_KILL_CNT_EN`; see Configuration.

## Operation
- Registers: `PC`, `state`, `kill`, `hold_instr`/`hold_pc`, IF/ID.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- `imem_req` = (state == FETCH). `imem_addr` = `PC`. Both depend on registers only; there is no combinational path from `PcSel`.
- **IDLE:** goes to FETCH next cycle. No request is issued.
- **FETCH:** a request for `PC` is issued, then the FSM goes to WAIT.
  - If `PcSel` is 1 in this cycle: `PC` <= target and `kill` <= 1, because the request is going to the stale PC.
- **WAIT with `imem_rvalid`:**
  - If `kill` or `PcSel` is 1: discard the response, clear `kill`, go to FETCH. If `PcSel` is 1, `PC` <= target.
  - Else if IF/ID can accept (`!Stall`): IF/ID <= {`PC`, `imem_rdata`, valid=1}, `PC` <= `PC`+4, go to FETCH.
  - Else: `hold_*` <= {`PC`, `imem_rdata`}, go to HOLD.
- **WAIT without `imem_rvalid`:** if `PcSel` is 1, `PC` <= target and `kill` <= 1. Stay in WAIT.
- **HOLD:**
  - If `PcSel` is 1: discard the held word, `PC` <= target, go to FETCH.
  - Else if `!Stall`: IF/ID <= hold, `PC` <= `PC`+4, go to FETCH.
- **IF/ID update priority:**
  1. `PcSel`: valid <= 0 (flush; this overrides `Stall`).
  2. `Stall`: hold.
  3. New word available: load it.
  4. Otherwise: valid <= 0 (bubble).
  - When valid goes to 0, `IfId_PC` and `IfId_Instr` keep their last values.
- **Arithmetic:** `PC`+4 wraps modulo 2^PC_W. Target = {`BrPC[PC_W-1:2]`, 2'b00}. Upper bits of `BrPC` are ignored.
- **Memory protocol:** at most one outstanding request. An `imem_rvalid` arriving outside WAIT is ignored.

## Timing
- Reset values (asynchronous):
  - `PC` = `RESET_PC`, state = IDLE, `kill` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `IfId_Valid` = 0, `IfId_PC` = 0, `IfId_Instr` = 0.
- The first request is issued in the 2nd cycle after `reset` deasserts.
- With memory latency L, fetch throughput is one instruction per 1+L cycles. The response loads IF/ID on the edge where `imem_rvalid` is sampled.
- A redirect takes effect on the same edge. The first request to the target is issued the next cycle, or after the killed response returns if the FSM was in FETCH or WAIT.
- `reset` asserted mid-transaction drops the outstanding request. The memory is expected to be reset by the same signal.

## Configuration
- `FETCH_KILL_CNT_EN` defined:
  - Adds the `Kill_Count` port: a 16-bit counter of discarded fetch words (killed responses plus dropped hold words).
  - Reset value 0, saturates at 16'hFFFF.
- Not defined: no port and no counter logic. All other behaviour is identical.

## Test plan
- **Straight-line fetch:** `RESET_PC`=0, L=1, no stall. Expect requests to 0,4,8,… every 2 cycles, and IF/ID to load each word with `IfId_Valid`=1 on the rvalid edge.
- **Redirect during WAIT:** `PcSel`=1 with `BrPC`=0x40 while the request to 0x08 is outstanding. Expect `IfId_Valid`=0 next cycle, the 0x08 response discarded, the next request to 0x40, and `Kill_Count`=1.
- **Redirect coincident with rvalid:** expect the response discarded, the next request to the target, and no IF/ID load.
- **Stall into HOLD:** `Stall`=1 for 3 cycles while the word for 0x10 returns. Expect IF/ID unchanged and no new request. After `Stall` drops, IF/ID = {0x10, word} and the next request is to 0x14.
- **Redirect in HOLD plus wrap:** `PcSel` in HOLD with `BrPC`=0xFFFF_FFFF and PC_W=9. Expect the next request to 0x1FC; after it is accepted, the following request is to 0x000.
- **Async reset mid-WAIT:** expect all outputs at their reset values immediately. After release, IDLE for 1 cycle, then a request to `RESET_PC`.
